// File: rtl/led_cube_bus_monitor.sv
// -----------------------------------------------------------------------------
// led_cube_bus_monitor
//
// Receive end of the LED cube Layers/Latches/Data drive bus. Shadows the eight
// column latches, captures the column image of each layer once its layer line
// has been held one-hot long enough, and publishes a complete 512-LED frame
// after all eight layers have been captured.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   enable       1 = monitor runs, 0 = freeze state (input registers still sample)
//   Layers[7:0]  one-hot layer enables, bit i = layer i
//   Latches[7:0] latch clocks, rising edge of bit i loads Data into column latch i
//   Data[7:0]    column data bus
//   frame_out    last completed frame, bit = layer*64 + latch*8 + data_bit
//   frame_valid  one-cycle pulse when frame_out updates
//   frame_count  completed frames since reset (wraps)
//   cur_layer    layer currently held one-hot (last valid value otherwise)
//   latch_err    sticky: more than one latch bit rose in the same cycle
//   layer_err    sticky: Layers seen multi-hot
// -----------------------------------------------------------------------------
module led_cube_bus_monitor #(
    parameter int MIN_HOLD = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [7:0]       Layers,
    input  logic [7:0]       Latches,
    input  logic [7:0]       Data,
    output logic [511:0]     frame_out,
    output logic             frame_valid,
    output logic [CNT_W-1:0] frame_count,
    output logic [2:0]       cur_layer,
    output logic             latch_err,
    output logic             layer_err
);

    localparam int HC_W = $clog2(MIN_HOLD + 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(MIN_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_CAPT = 2'd2
    } state_t;

    // Input stage
    logic [7:0]        r_layers_q, r_layers_d;
    logic [7:0]        r_latch_q, r_latch_d;
    logic [7:0]        r_latch_prev_q, r_latch_prev_d;
    logic [7:0]        r_data_q, r_data_d;

    // Column latch shadows and per-layer buffers; index = latch / layer
    logic [7:0][7:0]   shadow_q, shadow_d;
    logic [7:0][63:0]  buf_q, buf_d;
    logic [7:0]        seen_q, seen_d;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic [2:0]        cur_layer_q, cur_layer_d;

    logic [511:0]      frame_out_q, frame_out_d;
    logic              frame_valid_q, frame_valid_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;
    logic              latch_err_q, latch_err_d;
    logic              layer_err_q, layer_err_d;

    // Decoded input conditions
    logic [7:0]        rise;
    logic              multi_rise;
    logic              layers_zero;
    logic              layers_onehot;
    logic [2:0]        layers_idx;
    logic [7:0]        held_layers;
    logic              reenter;
    logic              capture;

    always_comb begin
        rise          = r_latch_q & ~r_latch_prev_q;
        // x & (x-1) clears the lowest set bit; non-zero result means >1 bits set
        multi_rise    = (rise & (rise - 8'd1)) != 8'd0;
        layers_zero   = (r_layers_q == 8'd0);
        layers_onehot = !layers_zero && ((r_layers_q & (r_layers_q - 8'd1)) == 8'd0);
        layers_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_layers_q[i]) begin
                layers_idx = 3'(i);
            end
        end
        held_layers   = 8'b1 << cur_layer_q;
    end

    always_comb begin
        r_layers_d     = Layers;
        r_latch_d      = Latches;
        r_data_d       = Data;
        r_latch_prev_d = r_latch_prev_q;
        shadow_d       = shadow_q;
        buf_d          = buf_q;
        seen_d         = seen_q;
        state_d        = state_q;
        hc_d           = hc_q;
        cur_layer_d    = cur_layer_q;
        frame_out_d    = frame_out_q;
        frame_valid_d  = 1'b0;
        frame_count_d  = frame_count_q;
        latch_err_d    = latch_err_q;
        layer_err_d    = layer_err_q;
        reenter        = 1'b0;
        capture        = 1'b0;

        if (enable) begin
            // Edge reference only advances while running, so edges that
            // happened while disabled are seen on re-enable.
            r_latch_prev_d = r_latch_q;

            for (int i = 0; i < 8; i++) begin
                if (rise[i]) begin
                    shadow_d[i] = r_data_q;
                end
            end
            if (multi_rise) begin
                latch_err_d = 1'b1;
            end

            // Completion runs off the registered seen mask, so the 8th
            // layer's capture is already in buf_q when the frame is published.
            if (seen_q == 8'hFF) begin
                frame_out_d   = buf_q;
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + CNT_W'(1);
                seen_d        = 8'd0;
            end

            case (state_q)
                S_IDLE: reenter = 1'b1;
                S_HOLD: begin
                    if (r_layers_q != held_layers) begin
                        reenter = 1'b1;
                    end else if (hc_q == HC_LAST) begin
                        capture = 1'b1;
                        state_d = S_CAPT;
                    end else begin
                        hc_d = hc_q + HC_W'(1);
                    end
                end
                S_CAPT: begin
                    if (r_layers_q != held_layers) begin
                        reenter = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A changed Layers value is evaluated exactly as IDLE would.
            if (reenter) begin
                if (layers_onehot) begin
                    state_d     = S_HOLD;
                    hc_d        = HC_W'(1);
                    cur_layer_d = layers_idx;
                end else begin
                    state_d = S_IDLE;
                    if (!layers_zero) begin
                        layer_err_d = 1'b1;
                    end
                end
            end

            if (capture) begin
                buf_d[cur_layer_q]  = shadow_q;
                seen_d[cur_layer_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_layers_q     <= '0;
            r_latch_q      <= '0;
            r_latch_prev_q <= '0;
            r_data_q       <= '0;
            shadow_q       <= '0;
            buf_q          <= '0;
            seen_q         <= '0;
            state_q        <= S_IDLE;
            hc_q           <= '0;
            cur_layer_q    <= '0;
            frame_out_q    <= '0;
            frame_valid_q  <= 1'b0;
            frame_count_q  <= '0;
            latch_err_q    <= 1'b0;
            layer_err_q    <= 1'b0;
        end else begin
            r_layers_q     <= r_layers_d;
            r_latch_q      <= r_latch_d;
            r_latch_prev_q <= r_latch_prev_d;
            r_data_q       <= r_data_d;
            shadow_q       <= shadow_d;
            buf_q          <= buf_d;
            seen_q         <= seen_d;
            state_q        <= state_d;
            hc_q           <= hc_d;
            cur_layer_q    <= cur_layer_d;
            frame_out_q    <= frame_out_d;
            frame_valid_q  <= frame_valid_d;
            frame_count_q  <= frame_count_d;
            latch_err_q    <= latch_err_d;
            layer_err_q    <= layer_err_d;
        end
    end

    assign frame_out   = frame_out_q;
    assign frame_valid = frame_valid_q;
    assign frame_count = frame_count_q;
    assign cur_layer   = cur_layer_q;
    assign latch_err   = latch_err_q;
    assign layer_err   = layer_err_q;

endmodule

// File: tb/tb_led_cube_bus_monitor.sv
// -----------------------------------------------------------------------------
// tb_led_cube_bus_monitor
//
// Directed bench for led_cube_bus_monitor. Stimulus tasks drive the cube bus
// and update a small bus-level model; every frame the model predicts is pushed
// into a queue and popped when the DUT pulses frame_valid.
// -----------------------------------------------------------------------------
module tb_led_cube_bus_monitor;

    localparam int MIN_HOLD = 4;
    localparam int CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [7:0]       Layers;
    logic [7:0]       Latches;
    logic [7:0]       Data;
    logic [511:0]     frame_out;
    logic             frame_valid;
    logic [CNT_W-1:0] frame_count;
    logic [2:0]       cur_layer;
    logic             latch_err;
    logic             layer_err;

    led_cube_bus_monitor #(.MIN_HOLD(MIN_HOLD), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .Layers      (Layers),
        .Latches     (Latches),
        .Data        (Data),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_count (frame_count),
        .cur_layer   (cur_layer),
        .latch_err   (latch_err),
        .layer_err   (layer_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0]     frame;
        logic [CNT_W-1:0] count;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_valid = 0;

    // Bus-level model
    logic [7:0][7:0]  m_sh;
    logic [7:0][63:0] m_buf;
    logic [7:0]       m_seen;
    int               m_count;
    int               m_cur;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            exp_t e;
            n_valid++;
            check("frame_expected", 512'(exp_q.size() != 0), 512'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("frame_out", frame_out, e.frame);
                check("frame_count", 512'(frame_count), 512'(e.count));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        m_sh    = '0;
        m_buf   = '0;
        m_seen  = '0;
        m_count = 0;
        m_cur   = 0;
    endtask

    task automatic model_capture(input int l);
        m_buf[l]  = m_sh;
        m_seen[l] = 1'b1;
        if (m_seen == 8'hFF) begin
            m_count++;
            exp_q.push_back({m_buf, CNT_W'(m_count)});
            m_seen = '0;
        end
    endtask

    task automatic load_latches(input logic [7:0][7:0] v);
        for (int k = 0; k < 8; k++) begin
            Data    = v[k];
            Latches = 8'(1 << k);
            tick(1);
            Latches = 8'h00;
            tick(1);
            m_sh[k] = v[k];
        end
    endtask

    task automatic fill(input logic [7:0] b);
        logic [7:0][7:0] v;
        for (int k = 0; k < 8; k++) v[k] = b;
        load_latches(v);
    endtask

    task automatic show_layer(input int l, input int cyc);
        m_cur = l;
        if (cyc >= MIN_HOLD) model_capture(l);
        Layers = 8'(1 << l);
        tick(cyc);
        Layers = 8'h00;
        tick(2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_frame_out"}, frame_out, 512'(0));
        check({tag, "_frame_valid"}, 512'(frame_valid), 512'(0));
        check({tag, "_frame_count"}, 512'(frame_count), 512'(0));
        check({tag, "_cur_layer"}, 512'(cur_layer), 512'(0));
        check({tag, "_latch_err"}, 512'(latch_err), 512'(0));
        check({tag, "_layer_err"}, 512'(layer_err), 512'(0));
    endtask

    task automatic do_reset(input string tag);
        Layers  = 8'h00;
        Latches = 8'h00;
        rst     = 1'b1;
        tick(1);
        check_zero(tag);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        logic [7:0][7:0] v;

        rst     = 1'b1;
        enable  = 1'b1;
        Layers  = 8'h00;
        Latches = 8'h00;
        Data    = 8'h00;
        model_clear();
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(2);

        // 1: full sweep, every byte 8'h81
        for (int l = 0; l < 8; l++) begin
            fill(8'h81);
            show_layer(l, 6);
            check($sformatf("t1_cur_layer_%0d", l), 512'(cur_layer), 512'(l));
        end
        tick(3);
        check("t1_valid_count", 512'(n_valid), 512'(1));

        // 2: too-short hold on layer 2 must not mark it seen
        fill(8'hC3);
        nv = n_valid;
        show_layer(2, MIN_HOLD - 1);
        check("t2_cur_layer", 512'(cur_layer), 512'(2));
        for (int l = 0; l < 8; l++) if (l != 2) show_layer(l, 6);
        tick(3);
        check("t2_no_frame", 512'(n_valid), 512'(nv));
        show_layer(2, 6);
        tick(3);
        check("t2_frame", 512'(n_valid), 512'(nv + 1));
        check("t2_latch_err_clear", 512'(latch_err), 512'(0));

        // 3: two latches rising together
        Data    = 8'h5A;
        Latches = 8'h03;
        tick(1);
        Latches = 8'h00;
        tick(2);
        m_sh[0] = 8'h5A;
        m_sh[1] = 8'h5A;
        check("t3_latch_err", 512'(latch_err), 512'(1));

        // 4: multi-hot layers, then a normal sweep
        check("t4_layer_err_before", 512'(layer_err), 512'(0));
        nv = n_valid;
        Layers = 8'h05;
        tick(10);
        Layers = 8'h00;
        tick(2);
        check("t4_layer_err", 512'(layer_err), 512'(1));
        check("t4_cur_layer_kept", 512'(cur_layer), 512'(m_cur));
        check("t4_no_frame", 512'(n_valid), 512'(nv));
        for (int l = 0; l < 8; l++) show_layer(l, 6);
        tick(3);
        check("t4_frame", 512'(n_valid), 512'(nv + 1));
        check("t4_latch_err_sticky", 512'(latch_err), 512'(1));

        // 5: re-show layer 3 with new data before the frame completes
        fill(8'h11);
        for (int l = 0; l < 7; l++) show_layer(l, 6);
        for (int k = 0; k < 8; k++) v[k] = 8'(8'h30 + k);
        load_latches(v);
        show_layer(3, 6);
        show_layer(7, 6);
        tick(3);
        check("t5_frame", 512'(n_valid), 512'(nv + 2));

        // 6: two sweeps around a disabled window, then reset mid-frame
        do_reset("t6_rst_a");
        for (int l = 0; l < 8; l++) begin
            for (int k = 0; k < 8; k++) v[k] = 8'(l * 16 + k);
            load_latches(v);
            show_layer(l, 6);
        end
        tick(3);
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 8; k++) v[k] = 8'(8'hA0 + l * 8 + k);
            load_latches(v);
            show_layer(l, 6);
        end
        nv     = n_valid;
        enable = 1'b0;
        Layers = 8'h20;
        for (int i = 0; i < 10; i++) begin
            Data    = 8'hFF;
            Latches = 8'(1 << (i % 8));
            tick(1);
            Latches = 8'h00;
            tick(1);
            check($sformatf("t6_disabled_valid_%0d", i), 512'(frame_valid), 512'(0));
        end
        Layers = 8'h00;
        tick(2);
        enable = 1'b1;
        tick(2);
        check("t6_disabled_no_frame", 512'(n_valid), 512'(nv));
        check("t6_cur_layer_frozen", 512'(cur_layer), 512'(3));
        check("t6_count_one", 512'(frame_count), 512'(1));
        for (int l = 4; l < 8; l++) show_layer(l, 6);
        tick(3);
        check("t6_count_two", 512'(frame_count), 512'(2));
        show_layer(0, 6);
        show_layer(1, 6);
        do_reset("t6_rst_b");
        fill(8'h77);
        nv = n_valid;
        for (int l = 2; l < 8; l++) show_layer(l, 6);
        tick(3);
        check("t6_partial_discarded", 512'(n_valid), 512'(nv));
        show_layer(0, 6);
        show_layer(1, 6);
        tick(3);
        check("t6_after_rst_frame", 512'(n_valid), 512'(nv + 1));

        tick(5);
        check("queue_drained", 512'(exp_q.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
